// File: rtl/bcd_score_display.sv
`default_nettype none
// ============================================================================
// Module   : bcd_score_display
// Purpose  : Edge-counted BCD score with high-score tracking, saturation flag
//            and a multiplexed active-low 7-segment driver.
//            Optional build macro: SEG_LEADING_ZERO_BLANK_EN (blank leading zeros).
// Revision : 1.0 - initial release
// ============================================================================
module bcd_score_display #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  inc,
    input  logic                  show_hi,
    output logic [4*DIGITS-1:0]   score,
    output logic [4*DIGITS-1:0]   hiscore,
    output logic                  ovf,
    output logic [7:0]            seg_out,
    output logic [DIGITS-1:0]     an
);

    localparam int c_idx_w = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int c_cnt_w = $clog2(SCAN_DIV);

    localparam logic [c_cnt_w-1:0] c_scan_last = c_cnt_w'(SCAN_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_idx_w-1:0] c_idx_last  = c_idx_w'(DIGITS - 1);
    localparam logic [c_idx_w-1:0] c_idx_one   = c_idx_w'(1);

    function automatic logic [7:0] f_seg(input logic [3:0] d);
        case (d)
            4'd0:    f_seg = 8'hC0;
            4'd1:    f_seg = 8'hF9;
            4'd2:    f_seg = 8'hA4;
            4'd3:    f_seg = 8'hB0;
            4'd4:    f_seg = 8'h99;
            4'd5:    f_seg = 8'h92;
            4'd6:    f_seg = 8'h82;
            4'd7:    f_seg = 8'hF8;
            4'd8:    f_seg = 8'h80;
            4'd9:    f_seg = 8'h90;
            default: f_seg = 8'hFF;
        endcase
    endfunction

    logic                  r_inc_q;
    logic [4*DIGITS-1:0]   r_score;
    logic [4*DIGITS-1:0]   r_hiscore;
    logic                  r_ovf;
    logic [c_cnt_w-1:0]    r_scan_cnt;
    logic [c_idx_w-1:0]    r_digit_idx;
    logic                  r_scan_active;
    logic [7:0]            r_seg;

    logic                  w_edge;
    logic [4*DIGITS-1:0]   w_score_inc;
    logic                  w_all_nines;
    logic                  w_carry;
    logic                  w_scan_tc;
    logic [c_idx_w-1:0]    w_idx_next;
    logic [4*DIGITS-1:0]   w_disp;
    logic [3:0]            w_digit;
    logic                  w_blank;

    assign w_edge = inc & ~r_inc_q;

    // Ripple a decimal carry from digit 0 upward; a carry out means all nines.
    always_comb begin
        w_score_inc = r_score;
        w_carry     = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (w_carry) begin
                if (r_score[4*k +: 4] == 4'd9) begin
                    w_score_inc[4*k +: 4] = 4'd0;
                end else begin
                    w_score_inc[4*k +: 4] = r_score[4*k +: 4] + 4'd1;
                    w_carry               = 1'b0;
                end
            end
        end
        w_all_nines = w_carry;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inc_q   <= 1'b0;
            r_score   <= '0;
            r_hiscore <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_inc_q <= inc;
            if (r_score > r_hiscore) begin
                r_hiscore <= r_score;
            end
            if (clear) begin
                r_score <= '0;
                r_ovf   <= 1'b0;
            end else if (w_edge) begin
                if (w_all_nines) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_score <= w_score_inc;
                end
            end
        end
    end

    // The first terminal count only enables the display, landing on digit 0.
    assign w_scan_tc = (r_scan_cnt == c_scan_last);

    always_comb begin
        w_idx_next = r_digit_idx;
        if (w_scan_tc && r_scan_active) begin
            w_idx_next = (r_digit_idx == c_idx_last) ? '0 : r_digit_idx + c_idx_one;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scan_cnt    <= '0;
            r_digit_idx   <= '0;
            r_scan_active <= 1'b0;
        end else begin
            r_scan_cnt  <= w_scan_tc ? '0 : r_scan_cnt + c_cnt_one;
            r_digit_idx <= w_idx_next;
            if (w_scan_tc) begin
                r_scan_active <= 1'b1;
            end
        end
    end

    assign w_disp = show_hi ? r_hiscore : r_score;

    // Segment data is fetched for the upcoming index so it lines up with an.
    always_comb begin
        w_digit = w_disp[3:0];
        for (int k = 0; k < DIGITS; k++) begin
            if (w_idx_next == c_idx_w'(k)) begin
                w_digit = w_disp[4*k +: 4];
            end
        end
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    always_comb begin
        w_blank = 1'b0;
        for (int k = 1; k < DIGITS; k++) begin
            if (w_idx_next == c_idx_w'(k)) begin
                w_blank = 1'b1;
                for (int j = k; j < DIGITS; j++) begin
                    if (w_disp[4*j +: 4] != 4'd0) begin
                        w_blank = 1'b0;
                    end
                end
            end
        end
    end
`else
    assign w_blank = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_seg <= 8'hFF;
        end else begin
            r_seg <= w_blank ? 8'hFF : f_seg(w_digit);
        end
    end

    always_comb begin
        an = '1;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_scan_active && (r_digit_idx == c_idx_w'(k))) begin
                an[k] = 1'b0;
            end
        end
    end

    assign score   = r_score;
    assign hiscore = r_hiscore;
    assign ovf     = r_ovf;
    assign seg_out = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_bcd_score_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_score_display
// Purpose  : Self-checking bench for bcd_score_display (DIGITS=4, SCAN_DIV=4)
//            against an arithmetic score/scan model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_score_display;

    localparam int D  = 4;
    localparam int SD = 4;

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic          clear   = 1'b0;
    logic          inc     = 1'b0;
    logic          show_hi = 1'b0;
    logic [15:0]   score;
    logic [15:0]   hiscore;
    logic          ovf;
    logic [7:0]    seg_out;
    logic [3:0]    an;

    always #5 clk = ~clk;

    bcd_score_display #(.DIGITS(D), .SCAN_DIV(SD)) dut (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .inc     (inc),
        .show_hi (show_hi),
        .score   (score),
        .hiscore (hiscore),
        .ovf     (ovf),
        .seg_out (seg_out),
        .an      (an)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: plain integers, cycles counted since reset release.
    int m_score, m_hi, m_n;
    bit m_ovf, m_inc_q;

    typedef struct {
        bit          inc;
        bit          clr;
        bit          shi;
        logic [15:0] score;
        logic [15:0] hi;
        bit          ovf;
    } vec_t;
    vec_t tbl[10];

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r = '0;
        for (int k = 0; k < D; k++) r[4*k +: 4] = 4'((v / (10**k)) % 10);
        return r;
    endfunction

    function automatic logic [7:0] seg_of(input int v, input int k);
        int d;
        d = (v / (10**k)) % 10;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (k > 0 && (v / (10**k)) == 0) return 8'hFF;
`endif
        case (d)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  default: return 8'h90;
        endcase
    endfunction

    function automatic int pos_of(input int n);
        return (n < SD) ? 0 : ((n / SD) - 1) % D;
    endfunction

    function automatic logic [3:0] an_of(input int n);
        logic [3:0] one;
        one = 4'b0001;
        if (n < SD) return 4'hF;
        return ~(one << pos_of(n));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock: advance the model with the current inputs, then compare.
    task automatic step();
        bit         edge_det;
        int         nn, new_hi, disp;
        logic [7:0] e_seg;
        logic [3:0] e_an;
        edge_det = inc && !m_inc_q;
        nn       = m_n + 1;
        disp     = show_hi ? m_hi : m_score;
        e_seg    = seg_of(disp, pos_of(nn));
        e_an     = an_of(nn);
        new_hi   = (m_score > m_hi) ? m_score : m_hi;
        if (clear) begin
            m_score = 0;
            m_ovf   = 1'b0;
        end else if (edge_det) begin
            if (m_score == 9999) m_ovf = 1'b1;
            else                 m_score = m_score + 1;
        end
        m_inc_q = inc;
        m_hi    = new_hi;
        m_n     = nn;
        @(posedge clk);
        #1;
        chk("score",   score,   to_bcd(m_score));
        chk("hiscore", hiscore, to_bcd(m_hi));
        chk("ovf",     ovf,     m_ovf);
        chk("an",      an,      e_an);
        chk("seg_out", seg_out, e_seg);
    endtask

    // Asserts reset between clock edges and checks the asynchronous effect.
    task automatic reset_now();
        inc = 1'b0; clear = 1'b0; show_hi = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        chk("rst_seg",   seg_out, 8'hFF);
        chk("rst_an",    an,      4'hF);
        chk("rst_score", score,   16'h0000);
        chk("rst_hi",    hiscore, 16'h0000);
        chk("rst_ovf",   ovf,     1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b1;
        m_score = 0; m_hi = 0; m_n = 0; m_ovf = 1'b0; m_inc_q = 1'b0;
    endtask

    task automatic pulse();
        inc = 1'b1; step();
        inc = 1'b0; step();
    endtask

    task automatic wait_an(input logic [3:0] target, input int budget);
        int i;
        i = 0;
        while (an !== target && i < budget) begin
            step();
            i++;
        end
        chk("wait_an", an, target);
    endtask

    logic [3:0] scan_an [4];
    logic [7:0] scan_seg[4];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b0, 16'h0001, 16'h0000, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 16'h0001, 16'h0001, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 16'h0002, 16'h0001, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 16'h0002, 16'h0002, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 16'h0002, 16'h0002, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 16'h0003, 16'h0002, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 16'h0003, 16'h0003, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 16'h0000, 16'h0003, 1'b0};
        tbl[8] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0003, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0003, 1'b0};
        scan_an  = '{4'hE, 4'hD, 4'hB, 4'h7};
        scan_seg = '{8'h99, 8'hB0, 8'hA4, 8'hF9};

        reset_now();
        foreach (tbl[i]) begin
            inc = tbl[i].inc; clear = tbl[i].clr; show_hi = tbl[i].shi;
            step();
            chk("tbl_score", score,   tbl[i].score);
            chk("tbl_hi",    hiscore, tbl[i].hi);
            chk("tbl_ovf",   ovf,     tbl[i].ovf);
        end
        clear = 1'b0; show_hi = 1'b0;

        // A level held high counts exactly once.
        inc = 1'b1;
        repeat (20) step();
        inc = 1'b0;
        step();
        chk("hold20", score, 16'h0001);

        while (m_score < 99) pulse();
        chk("at99", score, 16'h0099);
        pulse();
        chk("carry100", score, 16'h0100);
        while (m_score < 9999) pulse();
        chk("ovf_pre", ovf, 1'b0);
        pulse();
        chk("sat_score", score, 16'h9999);
        chk("sat_ovf",   ovf,   1'b1);
        pulse();
        chk("sat_sticky", ovf, 1'b1);
        clear = 1'b1; step(); clear = 1'b0;
        chk("clr_score", score,   16'h0000);
        chk("clr_ovf",   ovf,     1'b0);
        chk("clr_keephi", hiscore, 16'h9999);

        // Clear beats a simultaneous edge; hiscore survives.
        reset_now();
        repeat (42) pulse();
        clear = 1'b1; inc = 1'b1; step();
        clear = 1'b0; inc = 1'b0;
        chk("c42_score", score,   16'h0000);
        chk("c42_ovf",   ovf,     1'b0);
        chk("c42_hi",    hiscore, 16'h0042);
        show_hi = 1'b1;
        wait_an(4'hE, 40);
        chk("hi_d0", seg_out, 8'hA4);
        wait_an(4'hD, 40);
        chk("hi_d1", seg_out, 8'h99);
        show_hi = 1'b0;

        // Full scan of 1234.
        reset_now();
        repeat (1234) pulse();
        wait_an(4'h7, 40);
        wait_an(4'hE, 40);
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
                chk("scan_an",  an,      scan_an[d]);
                chk("scan_seg", seg_out, scan_seg[d]);
                step();
            end
        end

        // Leading zeros of 0005.
        reset_now();
        repeat (5) pulse();
        for (int d = 0; d < 4; d++) begin
            wait_an(scan_an[d], 40);
`ifdef SEG_LEADING_ZERO_BLANK_EN
            chk("lz_seg", seg_out, (d == 0) ? 8'h92 : 8'hFF);
`else
            chk("lz_seg", seg_out, (d == 0) ? 8'h92 : 8'hC0);
`endif
        end

        // Reset mid-scan with a nonzero score.
        reset_now();
        repeat (7) pulse();
        step(); step();
        reset_now();

        // Random traffic against the model, with one reset in the middle.
        for (int i = 0; i < 3000; i++) begin
            inc     = 1'($urandom_range(0, 1));
            clear   = ($urandom_range(0, 39) == 0);
            show_hi = ($urandom_range(0, 2) == 0);
            step();
            if (i == 1500) reset_now();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
